// File: rtl/sts_autocorr.sv
// Purpose : lag-DLY complex autocorrelation x[n]*conj(x[n-DLY]) summed over a sliding WIN-product window.
// Latency : 2 ap_clk cycles from input handshake to m_valid (stage 1 = P, stage 2 = C).
// Backpr. : single global advance enable; s_ready drops and every register holds while m_valid & !m_ready.
module sts_autocorr #(
    parameter int DLY = 16,
    parameter int WIN = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        clr,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_i,
    input  logic [15:0] s_q,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [32:0] m_re,
    output logic [32:0] m_im
);

    // Fill counter saturates once the sample and product lines are both primed.
    localparam int FILL = DLY + WIN;
    localparam int CW   = $clog2(FILL + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(FILL);
    localparam logic [CW-1:0] CNT_FIRST = CW'(FILL - 1);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_en;      // whole pipeline advances this cycle
    logic w_acc;     // input sample accepted this cycle
    logic w_flush;   // reset or packet restart, independent of w_en

    logic r_m_valid;

    assign w_en    = !r_m_valid || m_ready;
    assign w_flush = !ap_rst_n || clr;
    // A sample offered together with clr is dropped: restart wins.
    assign w_acc   = s_valid && w_en && !clr;
    assign s_ready = w_en;

    // ------------------------------------------------------------------
    // Sample delay line: index DLY-1 holds x[n-DLY]
    // ------------------------------------------------------------------
    logic [15:0] r_dly_i [DLY];
    logic [15:0] r_dly_q [DLY];

    // Shift accepted samples into the lag line; zero it on reset/clr.
    always_ff @(posedge ap_clk) begin
        if (w_flush) begin
            for (int k = 0; k < DLY; k++) begin
                r_dly_i[k] <= '0;
                r_dly_q[k] <= '0;
            end
        end else if (w_acc) begin
            r_dly_i[0] <= s_i;
            r_dly_q[0] <= s_q;
            for (int k = 1; k < DLY; k++) begin
                r_dly_i[k] <= r_dly_i[k-1];
                r_dly_q[k] <= r_dly_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Products: sign-extend to 32 bits so the 32x32 multiply keeps the
    // full 16x16 result (|product| <= 2^30, so no information is lost).
    // ------------------------------------------------------------------
    logic signed [31:0] w_i32, w_q32, w_id32, w_qd32;
    logic signed [31:0] w_ii, w_qq, w_qi, w_iq;
    logic signed [27:0] w_ii_t, w_qq_t, w_qi_t, w_iq_t;
    logic        [28:0] w_p_re, w_p_im;

    assign w_i32  = {{16{s_i[15]}}, s_i};
    assign w_q32  = {{16{s_q[15]}}, s_q};
    assign w_id32 = {{16{r_dly_i[DLY-1][15]}}, r_dly_i[DLY-1]};
    assign w_qd32 = {{16{r_dly_q[DLY-1][15]}}, r_dly_q[DLY-1]};

    assign w_ii = w_i32 * w_id32;
    assign w_qq = w_q32 * w_qd32;
    assign w_qi = w_q32 * w_id32;
    assign w_iq = w_i32 * w_qd32;

    // Arithmetic shift floors toward minus infinity; the 28 kept bits
    // hold every shifted value exactly.
    assign w_ii_t = 28'(w_ii >>> 4);
    assign w_qq_t = 28'(w_qq >>> 4);
    assign w_qi_t = 28'(w_qi >>> 4);
    assign w_iq_t = 28'(w_iq >>> 4);

    // P = x[n] * conj(x[n-DLY]); one extra bit makes the 28+28 sum exact.
    assign w_p_re = {w_ii_t[27], w_ii_t} + {w_qq_t[27], w_qq_t};
    assign w_p_im = {w_qi_t[27], w_qi_t} - {w_iq_t[27], w_iq_t};

    // ------------------------------------------------------------------
    // Fill counter
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;

    // Count accepted samples since reset/clr, saturating at DLY+WIN.
    always_ff @(posedge ap_clk) begin
        if (w_flush) begin
            r_cnt <= '0;
        end else if (w_acc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register P. r_s1_act marks a real sample (it must still be
    // accumulated), r_s1_out marks one whose result is to be presented.
    // ------------------------------------------------------------------
    logic        r_s1_act;
    logic        r_s1_out;
    logic [28:0] r_p_re;
    logic [28:0] r_p_im;

    // Load stage 1 with the new product, or a bubble when nothing is accepted.
    always_ff @(posedge ap_clk) begin
        if (w_flush) begin
            r_s1_act <= 1'b0;
            r_s1_out <= 1'b0;
            r_p_re   <= '0;
            r_p_im   <= '0;
        end else if (w_en) begin
            r_s1_act <= w_acc;
            r_s1_out <= w_acc && (r_cnt >= CNT_FIRST);
            if (w_acc) begin
                r_p_re <= w_p_re;
                r_p_im <= w_p_im;
            end
        end
    end

    // ------------------------------------------------------------------
    // Product delay line: index WIN-1 holds P[n-WIN] relative to stage 1
    // ------------------------------------------------------------------
    logic        w_adv2;
    logic [28:0] r_pd_re [WIN];
    logic [28:0] r_pd_im [WIN];

    assign w_adv2 = w_en && r_s1_act;

    // Shift each accumulated product into the window line; zero it on reset/clr.
    always_ff @(posedge ap_clk) begin
        if (w_flush) begin
            for (int k = 0; k < WIN; k++) begin
                r_pd_re[k] <= '0;
                r_pd_im[k] <= '0;
            end
        end else if (w_adv2) begin
            r_pd_re[0] <= r_p_re;
            r_pd_im[0] <= r_p_im;
            for (int k = 1; k < WIN; k++) begin
                r_pd_re[k] <= r_pd_re[k-1];
                r_pd_im[k] <= r_pd_im[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: running window sum C += P[n] - P[n-WIN], 33-bit signed.
    // The window sum is bounded by WIN * 2^27 = 2^31, so it cannot wrap.
    // ------------------------------------------------------------------
    logic [32:0] r_c_re, r_c_im;
    logic [32:0] w_c_re_nxt, w_c_im_nxt;

    assign w_c_re_nxt = r_c_re
                      + {{4{r_p_re[28]}}, r_p_re}
                      - {{4{r_pd_re[WIN-1][28]}}, r_pd_re[WIN-1]};
    assign w_c_im_nxt = r_c_im
                      + {{4{r_p_im[28]}}, r_p_im}
                      - {{4{r_pd_im[WIN-1][28]}}, r_pd_im[WIN-1]};

    // Update the accumulators only when stage 1 carries a real sample.
    always_ff @(posedge ap_clk) begin
        if (w_flush) begin
            r_c_re <= '0;
            r_c_im <= '0;
        end else if (w_adv2) begin
            r_c_re <= w_c_re_nxt;
            r_c_im <= w_c_im_nxt;
        end
    end

    // Output valid follows stage 1's present flag; bubbles clear it once taken.
    always_ff @(posedge ap_clk) begin
        if (w_flush) begin
            r_m_valid <= 1'b0;
        end else if (w_en) begin
            r_m_valid <= r_s1_out;
        end
    end

    assign m_valid = r_m_valid;
    assign m_re    = r_c_re;
    assign m_im    = r_c_im;

endmodule

// File: tb/tb_sts_autocorr.sv
// Directed bench for sts_autocorr: expected windowed correlations are worked by hand.
module tb_sts_autocorr;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        clr;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_i;
    logic [15:0] s_q;
    logic        m_valid;
    logic        m_ready;
    logic [32:0] m_re;
    logic [32:0] m_im;

    int n_checks = 0;
    int n_pass   = 0;

    sts_autocorr #(.DLY(16), .WIN(16)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (clr),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_i      (s_i),
        .s_q      (s_q),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_re     (m_re),
        .m_im     (m_im)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        clr      = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        s_i      = '0;
        s_q      = '0;
        tick();
        tick();
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        clr      = 1'b0;
        s_valid  = 1'b1;
        s_i      = 16'd1000;
        s_q      = 16'd0;
        m_ready  = 1'b1;
        tick();
        tick();
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (m_re !== 33'd0) $display("FAIL reset_m_re: got %0h want 0", m_re); else n_pass++;
        n_checks++; if (m_im !== 33'd0) $display("FAIL reset_m_im: got %0h want 0", m_im); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
        s_valid  = 1'b0;
        ap_rst_n = 1'b1;
    endtask

    // 40 x (1000,0): output for sample k-1 is visible after the edge accepting sample k.
    task automatic test_constant();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            s_valid = 1'b1; s_i = 16'd1000; s_q = 16'd0;
            tick();
            n_checks++; if (m_valid !== (k >= 32)) $display("FAIL const_valid k=%0d: got %b want %b", k, m_valid, (k >= 32)); else n_pass++;
            if (k >= 32) begin
                n_checks++; if (m_re !== 33'd1000000) $display("FAIL const_re k=%0d: got %0d want 1000000", k, m_re); else n_pass++;
                n_checks++; if (m_im !== 33'd0) $display("FAIL const_im k=%0d: got %0d want 0", k, m_im); else n_pass++;
            end
        end
        s_valid = 1'b0;
        tick();
        n_checks++; if (m_valid !== 1'b1) $display("FAIL const_last_valid: got %b want 1", m_valid); else n_pass++;
        n_checks++; if (m_re !== 33'd1000000) $display("FAIL const_last_re: got %0d want 1000000", m_re); else n_pass++;
        tick();
        n_checks++; if (m_valid !== 1'b0) $display("FAIL const_bubble_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL const_bubble_ready: got %b want 1", s_ready); else n_pass++;
    endtask

    // 16 x (1000,0) then (0,1000): window rotates from pure imaginary to pure real.
    task automatic test_phase_step();
        do_reset();
        for (int k = 0; k < 50; k++) begin
            s_valid = 1'b1;
            if (k < 16) begin s_i = 16'd1000; s_q = 16'd0; end
            else        begin s_i = 16'd0;    s_q = 16'd1000; end
            tick();
            if (k == 31) begin
                n_checks++; if (m_valid !== 1'b0) $display("FAIL phase_early_valid: got %b want 0", m_valid); else n_pass++;
            end
            if (k == 32) begin
                n_checks++; if (m_valid !== 1'b1) $display("FAIL phase_first_valid: got %b want 1", m_valid); else n_pass++;
                n_checks++; if (m_re !== 33'd0) $display("FAIL phase_first_re: got %0d want 0", m_re); else n_pass++;
                n_checks++; if (m_im !== 33'd1000000) $display("FAIL phase_first_im: got %0d want 1000000", m_im); else n_pass++;
            end
            if (k == 33) begin
                n_checks++; if (m_re !== 33'd62500) $display("FAIL phase_second_re: got %0d want 62500", m_re); else n_pass++;
                n_checks++; if (m_im !== 33'd937500) $display("FAIL phase_second_im: got %0d want 937500", m_im); else n_pass++;
            end
            if (k == 48 || k == 49) begin
                n_checks++; if (m_re !== 33'd1000000) $display("FAIL phase_steady_re k=%0d: got %0d want 1000000", k, m_re); else n_pass++;
                n_checks++; if (m_im !== 33'd0) $display("FAIL phase_steady_im k=%0d: got %0d want 0", k, m_im); else n_pass++;
            end
        end
        s_valid = 1'b0;
    endtask

    // (-1)*1 >>> 4 floors to -1, so 16 such products sum to -16 (truncation toward zero would give 0).
    task automatic test_floor_shift();
        logic [32:0] e_neg;
        e_neg = -33'sd16;
        do_reset();
        for (int k = 0; k < 33; k++) begin
            s_valid = 1'b1;
            s_i = (k < 16) ? 16'h0001 : 16'hFFFF;
            s_q = 16'd0;
            tick();
        end
        s_valid = 1'b0;
        n_checks++; if (m_valid !== 1'b1) $display("FAIL floor_valid: got %b want 1", m_valid); else n_pass++;
        n_checks++; if (m_re !== e_neg) $display("FAIL floor_re: got %0h want %0h", m_re, e_neg); else n_pass++;
        n_checks++; if (m_im !== 33'd0) $display("FAIL floor_im: got %0h want 0", m_im); else n_pass++;
    endtask

    // All (-32768,-32768): each product 2^30 -> 2^26, P.re = 2^27, C.re = 2^31.
    task automatic test_extreme();
        do_reset();
        for (int k = 0; k < 34; k++) begin
            s_valid = 1'b1; s_i = 16'h8000; s_q = 16'h8000;
            tick();
            if (k >= 32) begin
                n_checks++; if (m_valid !== 1'b1) $display("FAIL extreme_valid k=%0d: got %b want 1", k, m_valid); else n_pass++;
                n_checks++; if (m_re !== 33'h0_8000_0000) $display("FAIL extreme_re k=%0d: got %0h want 080000000", k, m_re); else n_pass++;
                n_checks++; if (m_im !== 33'd0) $display("FAIL extreme_im k=%0d: got %0h want 0", k, m_im); else n_pass++;
            end
        end
        s_valid = 1'b0;
    endtask

    // Phase-step stream gives distinct outputs: result n (31..47) = (62500*(n-31), 62500*(47-n)).
    // A 5-cycle stall lands on result 35; each result must appear once, in order.
    task automatic test_backpressure();
        int          n_in;
        int          exp_n;
        int          stall_left;
        bit          stalled;
        logic [32:0] e_re;
        logic [32:0] e_im;
        do_reset();
        n_in = 0; exp_n = 31; stall_left = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 300 && exp_n < 48; cyc++) begin
            if (!stalled && m_valid && exp_n == 35) begin
                stall_left = 5;
                stalled    = 1'b1;
            end
            m_ready = (stall_left == 0);
            s_valid = (n_in < 48);
            if (n_in < 16) begin s_i = 16'd1000; s_q = 16'd0; end
            else           begin s_i = 16'd0;    s_q = 16'd1000; end
            #1;
            e_re = 33'(62500 * (exp_n - 31));
            e_im = 33'(62500 * (47 - exp_n));
            if (stall_left > 0) begin
                n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_stall_ready: got %b want 0", s_ready); else n_pass++;
                n_checks++; if (m_valid !== 1'b1) $display("FAIL bp_stall_valid: got %b want 1", m_valid); else n_pass++;
                n_checks++; if (m_re !== e_re) $display("FAIL bp_stall_re n=%0d: got %0d want %0d", exp_n, m_re, e_re); else n_pass++;
                n_checks++; if (m_im !== e_im) $display("FAIL bp_stall_im n=%0d: got %0d want %0d", exp_n, m_im, e_im); else n_pass++;
                stall_left--;
            end else if (m_valid) begin
                n_checks++; if (m_re !== e_re) $display("FAIL bp_re n=%0d: got %0d want %0d", exp_n, m_re, e_re); else n_pass++;
                n_checks++; if (m_im !== e_im) $display("FAIL bp_im n=%0d: got %0d want %0d", exp_n, m_im, e_im); else n_pass++;
                exp_n++;
            end
            if (s_valid && s_ready) n_in++;
            tick();
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        n_checks++; if (exp_n != 48) $display("FAIL bp_timeout: got %0d results want 17", exp_n - 31); else n_pass++;
        n_checks++; if (stalled != 1'b1) $display("FAIL bp_no_stall: got %b want 1", stalled); else n_pass++;
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL bp_extra_output: got %b want 0", m_valid); else n_pass++;
    endtask

    // clr on sample 35 while stalled: must still clear, drop the sample, and force a full refill.
    task automatic test_clr();
        do_reset();
        for (int k = 0; k < 35; k++) begin
            s_valid = 1'b1; s_i = 16'd1000; s_q = 16'd0;
            tick();
        end
        m_ready = 1'b0;
        clr     = 1'b1;
        #1;
        n_checks++; if (m_valid !== 1'b1) $display("FAIL clr_pre_valid: got %b want 1", m_valid); else n_pass++;
        tick();
        clr     = 1'b0;
        m_ready = 1'b1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL clr_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (m_re !== 33'd0) $display("FAIL clr_re: got %0d want 0", m_re); else n_pass++;
        n_checks++; if (m_im !== 33'd0) $display("FAIL clr_im: got %0d want 0", m_im); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL clr_ready: got %b want 1", s_ready); else n_pass++;
        for (int k = 0; k < 34; k++) begin
            s_valid = 1'b1; s_i = 16'd1000; s_q = 16'd0;
            tick();
            n_checks++; if (m_valid !== (k >= 32)) $display("FAIL clr_refill_valid k=%0d: got %b want %b", k, m_valid, (k >= 32)); else n_pass++;
            if (k >= 32) begin
                n_checks++; if (m_re !== 33'd1000000) $display("FAIL clr_refill_re k=%0d: got %0d want 1000000", k, m_re); else n_pass++;
            end
        end
        s_valid = 1'b0;
        tick();
        tick();
    endtask

    // One-cycle reset mid-stream, then the constant-input behaviour from scratch.
    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 36; k++) begin
            s_valid = 1'b1; s_i = 16'd1000; s_q = 16'd0;
            tick();
        end
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (m_re !== 33'd0) $display("FAIL rstmid_re: got %0d want 0", m_re); else n_pass++;
        n_checks++; if (m_im !== 33'd0) $display("FAIL rstmid_im: got %0d want 0", m_im); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            s_valid = 1'b1; s_i = 16'd1000; s_q = 16'd0;
            tick();
            n_checks++; if (m_valid !== (k >= 32)) $display("FAIL rstmid_refill_valid k=%0d: got %b want %b", k, m_valid, (k >= 32)); else n_pass++;
            if (k >= 32) begin
                n_checks++; if (m_re !== 33'd1000000) $display("FAIL rstmid_refill_re k=%0d: got %0d want 1000000", k, m_re); else n_pass++;
                n_checks++; if (m_im !== 33'd0) $display("FAIL rstmid_refill_im k=%0d: got %0d want 0", k, m_im); else n_pass++;
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        clr      = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        s_i      = '0;
        s_q      = '0;
        test_reset();
        test_constant();
        test_phase_step();
        test_floor_shift();
        test_extreme();
        test_backpressure();
        test_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sts_autocorr.md
STS_AUTOCORR -- requirements
Module: sts_autocorr

Interface
REQ-001 SHALL have parameter DLY, default 16, giving the autocorrelation lag in samples.
REQ-002 SHALL have parameter WIN, default 16, giving the sliding-window length in products.
REQ-003 ap_clk  in  1  sole clock; all logic on rising edge.
REQ-004 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-005 clr  in  1  synchronous restart for a new packet, active-high.
REQ-006 s_valid  in  1  input sample valid.
REQ-007 s_ready  out  1  input sample accepted when s_valid and s_ready are both high.
REQ-008 s_i, s_q  in  16 each  signed I/Q sample.
REQ-009 m_valid  out  1  output correlation valid.
REQ-010 m_ready  in  1  downstream accept.
REQ-011 m_re, m_im  out  33 each  signed windowed correlation.

Function
REQ-012 SHALL compute P[n] = x[n]*conj(x[n-DLY]) for each accepted sample x[n].
- re = I*Id + Q*Qd
- im = Q*Id - I*Qd
REQ-013 Each of the four products SHALL be computed full-precision signed 32-bit, then arithmetic-shifted right by 4 (truncation toward minus infinity) to 28 bits.
REQ-014 Each of P.re and P.im SHALL be the 29-bit signed sum or difference of two such 28-bit terms, with no saturation.
REQ-015 The accumulators SHALL update as C[n] = C[n-1] + P[n] - P[n-WIN], at 33-bit signed width.
- Accumulation is exact; no overflow is possible with the defaults.
REQ-016 SHALL keep a DLY-deep sample delay line and a WIN-deep product delay line; both hold zeros after reset or clr.
REQ-017 The pipeline SHALL have two stages: stage 1 registers the products and P; stage 2 registers C.
- Latency is 2 ap_clk cycles from acceptance to m_valid when m_ready is held high.
REQ-018 SHALL use a global advance enable en = !m_valid | m_ready.
- s_ready = en.
- No state changes while en is low.
- m_re, m_im and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-019 SHALL count accepted samples since reset or clr in a counter saturating at DLY+WIN.
- m_valid asserts only for results of sample index >= DLY+WIN-1, counting from 0 (the 32nd sample with defaults).
- Earlier results advance through the pipeline but are discarded with m_valid=0.
REQ-020 With s_valid low and en high, stages SHALL advance bubbles; m_valid deasserts after the last valid result is taken.
REQ-021 clr SHALL take effect on the same edge regardless of en.
- Clears delay lines, accumulators, the fill counter, pipeline valids and m_valid.
- Any sample presented in the clr cycle is dropped.
- clr has priority over the input handshake.
REQ-022 Wrap-around SHALL be impossible for any input; the worst case |C| = 2^31 fits 33 bits.

Reset
REQ-023 On ap_clk with ap_rst_n=0, SHALL apply the same clearing as clr: all outputs 0, m_valid=0, all delay-line and accumulator state 0.
- s_ready = 1 during and after reset, since m_valid=0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight results; the first output after release requires a full DLY+WIN refill.

Verification
REQ-025 Constant input: reset, then 40 samples of (1000,0) with m_ready=1 -> first m_valid 2 cycles after the 32nd acceptance with m_re=1000000, m_im=0; every later output is the same.
REQ-026 Phase step: 16 samples of (1000,0), then (0,1000) continuously -> first valid output m_re=0, m_im=1000000; at steady state 16 samples later, m_re=1000000, m_im=0.
REQ-027 Extreme input: all samples (-32768,-32768) -> steady-state m_re=2147483648 (2^31), m_im=0; no wrap.
REQ-028 Backpressure: m_ready=0 for 5 cycles while m_valid=1 -> s_ready=0 and outputs held; on release the output sequence is identical to a no-stall run, with no loss or duplication.
REQ-029 clr at sample 35 of a constant (1000,0) stream -> m_valid=0 next cycle; the next valid output appears only after 32 fresh samples, with value 1000000.
REQ-030 ap_rst_n low for 1 cycle mid-stream -> m_valid=0 and m_re=m_im=0 after the edge; behaviour thereafter is identical to REQ-025.
